// File: rtl/gpmc_bus_frontend_pkg.sv
// Shared types and constants for the GPMC bus front end.
package gpmc_bus_frontend_pkg;

  localparam int unsigned GPMC_ADDR_W = 17;
  localparam int unsigned GPMC_DATA_W = 16;

  localparam logic [GPMC_DATA_W-1:0] RD_TIMEOUT_DATA = 16'hDEAD;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    RD_WAIT = 2'd2,
    RD_DATA = 2'd3
  } gpmc_state_t;

  typedef struct packed {
    logic [GPMC_ADDR_W-1:0] addr;
    logic [GPMC_DATA_W-1:0] data;
  } wr_entry_t;

  // Saturating 8-bit event counter increment.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/gpmc_wr_fifo.sv
// Synchronous show-ahead FIFO; head entry is visible on o_data whenever o_empty is low.
module gpmc_wr_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 33
) (
  input  logic             gpmc_clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_pop_ok;
  logic             w_push_ok;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_data    = r_mem[r_rd_ptr];
  assign w_pop_ok  = i_pop & ~o_empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push_ok = i_push & (~o_full | w_pop_ok);

  always_ff @(posedge gpmc_clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge gpmc_clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/gpmc_bus_frontend.sv
// GPMC-domain front end: decodes muxed A/D sync cycles, buffers write bursts,
// and stalls reads with WAIT until the downstream response returns.
module gpmc_bus_frontend
  import gpmc_bus_frontend_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 17,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned RD_TIMEOUT = 255
) (
  input  logic                  gpmc_clk,
  input  logic                  reset,
  input  logic [15:0]           gpmc_ad_in,
  output logic [15:0]           gpmc_ad_out,
  output logic                  gpmc_ad_oe,
  input  logic                  gpmc_adv_n,
  input  logic                  gpmc_cs_n,
  input  logic                  gpmc_we_n,
  input  logic                  gpmc_oe_n,
  output logic                  gpmc_wait,
  output logic                  wr_valid,
  input  logic                  wr_ready,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_req,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_resp_valid,
  input  logic [DATA_WIDTH-1:0] rd_resp_data,
  output logic [7:0]            ovf_count,
  output logic [7:0]            to_count
);

  localparam int unsigned TW = $clog2(RD_TIMEOUT + 1);
  localparam int unsigned EW = $bits(wr_entry_t);

  gpmc_state_t           r_state,       w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr_q,      w_addr_q_nxt;
  logic                  r_outstanding, w_outstanding_nxt;
  logic [TW-1:0]         r_timer,       w_timer_nxt;
  logic [DATA_WIDTH-1:0] r_rd_data,     w_rd_data_nxt;
  logic                  r_rd_req,      w_rd_req_nxt;
  logic [ADDR_WIDTH-1:0] r_rd_addr,     w_rd_addr_nxt;
  logic                  r_wait,        w_wait_nxt;
  logic                  r_ad_oe,       w_ad_oe_nxt;
  logic [7:0]            r_ovf,         w_ovf_nxt;
  logic [7:0]            r_to,          w_to_nxt;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  wr_entry_t             w_push_entry;
  wr_entry_t             w_head;
  logic [EW-1:0]         w_head_raw;

  assign w_pop             = ~w_empty & wr_ready;
  assign w_push_entry.addr = GPMC_ADDR_W'(r_addr_q);
  assign w_push_entry.data = GPMC_DATA_W'(gpmc_ad_in);
  assign w_head            = wr_entry_t'(w_head_raw);

  gpmc_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_wr_fifo (
    .gpmc_clk (gpmc_clk),
    .reset    (reset),
    .i_push   (w_push),
    .i_data   (w_push_entry),
    .i_pop    (w_pop),
    .o_data   (w_head_raw),
    .o_full   (w_full),
    .o_empty  (w_empty)
  );

  // Next-state and registered-output logic.
  always_comb begin
    w_state_nxt       = r_state;
    w_addr_q_nxt      = r_addr_q;
    w_outstanding_nxt = r_outstanding;
    w_timer_nxt       = r_timer;
    w_rd_data_nxt     = r_rd_data;
    w_rd_req_nxt      = 1'b0;
    w_rd_addr_nxt     = r_rd_addr;
    w_ovf_nxt         = r_ovf;
    w_to_nxt          = r_to;
    w_push            = 1'b0;

    if (gpmc_cs_n) begin
      w_state_nxt       = IDLE;
      w_outstanding_nxt = 1'b0;
    end else if (!gpmc_adv_n && r_state != RD_WAIT) begin
      w_state_nxt       = ACTIVE;
      w_addr_q_nxt      = ADDR_WIDTH'({gpmc_ad_in, 1'b0});
      w_outstanding_nxt = 1'b0;
    end else begin
      case (r_state)
        ACTIVE: begin
          if (!gpmc_we_n) begin
            w_push       = 1'b1;
            w_addr_q_nxt = r_addr_q + ADDR_WIDTH'(2);
            if (w_full && !w_pop) begin
              w_ovf_nxt = sat_inc8(r_ovf);
            end
          end else if (!gpmc_oe_n) begin
            w_state_nxt = RD_WAIT;
          end
        end
        RD_WAIT: begin
          // Reads are held back until every buffered write has drained.
          if (!r_outstanding) begin
            if (w_empty) begin
              w_rd_req_nxt      = 1'b1;
              w_rd_addr_nxt     = r_addr_q;
              w_outstanding_nxt = 1'b1;
              w_timer_nxt       = '0;
            end
          end else if (rd_resp_valid) begin
            w_rd_data_nxt     = rd_resp_data;
            w_outstanding_nxt = 1'b0;
            w_state_nxt       = RD_DATA;
          end else if (r_timer == TW'(RD_TIMEOUT)) begin
            w_rd_data_nxt     = DATA_WIDTH'(RD_TIMEOUT_DATA);
            w_to_nxt          = sat_inc8(r_to);
            w_outstanding_nxt = 1'b0;
            w_state_nxt       = RD_DATA;
          end else begin
            w_timer_nxt = r_timer + TW'(1);
          end
        end
        RD_DATA: begin
          if (gpmc_oe_n) begin
            w_state_nxt  = ACTIVE;
            w_addr_q_nxt = r_addr_q + ADDR_WIDTH'(2);
          end
        end
        default: begin
          w_state_nxt = r_state;
        end
      endcase
    end

    w_wait_nxt  = (w_state_nxt == RD_WAIT);
    w_ad_oe_nxt = (w_state_nxt == RD_DATA) && !gpmc_cs_n && !gpmc_oe_n;
  end

  always_ff @(posedge gpmc_clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_addr_q      <= '0;
      r_outstanding <= 1'b0;
      r_timer       <= '0;
      r_rd_data     <= '0;
      r_rd_req      <= 1'b0;
      r_rd_addr     <= '0;
      r_wait        <= 1'b0;
      r_ad_oe       <= 1'b0;
      r_ovf         <= '0;
      r_to          <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_addr_q      <= w_addr_q_nxt;
      r_outstanding <= w_outstanding_nxt;
      r_timer       <= w_timer_nxt;
      r_rd_data     <= w_rd_data_nxt;
      r_rd_req      <= w_rd_req_nxt;
      r_rd_addr     <= w_rd_addr_nxt;
      r_wait        <= w_wait_nxt;
      r_ad_oe       <= w_ad_oe_nxt;
      r_ovf         <= w_ovf_nxt;
      r_to          <= w_to_nxt;
    end
  end

  // Head fields read as zero while the FIFO is empty.
  assign wr_valid    = ~w_empty;
  assign wr_addr     = w_empty ? '0 : ADDR_WIDTH'(w_head.addr);
  assign wr_data     = w_empty ? '0 : DATA_WIDTH'(w_head.data);
  assign gpmc_ad_out = 16'(r_rd_data);
  assign gpmc_ad_oe  = r_ad_oe;
  assign gpmc_wait   = r_wait;
  assign rd_req      = r_rd_req;
  assign rd_addr     = r_rd_addr;
  assign ovf_count   = r_ovf;
  assign to_count    = r_to;

endmodule
